// File: rtl/usb_bridge_pkg.sv
// Shared constants for the USB host-bus bridge: FSM encoding, counter default, idle strobe level.
package usb_bridge_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_TURN  = 2'd3;

  localparam int DEF_CNT_W = 16;

  // Active-low strobes rest high.
  localparam logic IDLE_STROBE = 1'b1;

endpackage

// File: rtl/usb_bridge_stats.sv
// Per-channel saturating write/read transaction counters; instantiated only when USB_BRIDGE_STATS_EN is defined.
module usb_bridge_stats
  import usb_bridge_pkg::*;
#(
  parameter int pNUM_CH = 4,
  parameter int pCH_W   = 2,
  parameter int pCNT_W  = DEF_CNT_W
) (
  input  logic                      usb_clk,
  input  logic                      reset,
  input  logic                      stat_clr,
  input  logic                      wr_inc,
  input  logic                      rd_inc,
  input  logic [pCH_W-1:0]          ch,
  output logic [pCNT_W*pNUM_CH-1:0] wr_count,
  output logic [pCNT_W*pNUM_CH-1:0] rd_count
);

  localparam logic [pCNT_W-1:0] CNT_MAX = '1;

  for (genvar g = 0; g < pNUM_CH; g++) begin : g_ch
    localparam logic [pCH_W-1:0] CH_ID = pCH_W'(g);
    logic [pCNT_W-1:0] wr_q;
    logic [pCNT_W-1:0] rd_q;

    // Clear takes priority over a coincident increment.
    always_ff @(posedge usb_clk or posedge reset) begin
      if (reset) begin
        wr_q <= '0;
        rd_q <= '0;
      end else if (stat_clr) begin
        wr_q <= '0;
        rd_q <= '0;
      end else begin
        if (wr_inc && (ch == CH_ID) && (wr_q != CNT_MAX)) wr_q <= wr_q + pCNT_W'(1);
        if (rd_inc && (ch == CH_ID) && (rd_q != CNT_MAX)) rd_q <= rd_q + pCNT_W'(1);
      end
    end

    assign wr_count[g*pCNT_W +: pCNT_W] = wr_q;
    assign rd_count[g*pCNT_W +: pCNT_W] = rd_q;
  end

endmodule

// File: rtl/usb_bus_bridge.sv
// Registered multi-channel bridge from the host parallel bus to pNUM_CH external target buses.
// Optional per-channel statistics counters are built when USB_BRIDGE_STATS_EN is defined.
module usb_bus_bridge
  import usb_bridge_pkg::*;
#(
  parameter int pADDR_WIDTH = 11,
  parameter int pNUM_CH     = 4,
  parameter int pCH_W       = 2,
  parameter int pCNT_W      = DEF_CNT_W
) (
  input  logic                      usb_clk,
  input  logic                      reset,
  input  logic [pADDR_WIDTH-1:0]    I_usb_addr,
  input  logic [7:0]                I_usb_data,
  output logic [7:0]                O_usb_data,
  output logic                      O_usb_data_oe,
  input  logic                      I_usb_rdn,
  input  logic                      I_usb_wrn,
  input  logic                      I_usb_cen,
  input  logic [pCH_W-1:0]          I_ch_sel,
  output logic [pADDR_WIDTH-1:0]    O_ext_addr,
  output logic [7:0]                O_ext_data,
  output logic                      O_ext_data_oe,
  input  logic [8*pNUM_CH-1:0]      I_ext_data,
  output logic [pNUM_CH-1:0]        O_ext_rdn,
  output logic [pNUM_CH-1:0]        O_ext_wrn,
  output logic [pNUM_CH-1:0]        O_ext_cen,
  output logic [pCH_W-1:0]          O_active_ch,
  output logic                      O_busy,
  output logic                      O_proto_err,
  input  logic                      I_err_clr,
  input  logic                      I_stat_clr,
  output logic [pCNT_W*pNUM_CH-1:0] O_wr_count,
  output logic [pCNT_W*pNUM_CH-1:0] O_rd_count
);

  localparam int CH_W1 = pCH_W + 1;
  localparam logic [pCH_W:0] NUM_CH_V = CH_W1'(pNUM_CH);

  logic [1:0] state, state_nxt;
  logic       s1_rdn, s1_wrn, s1_cen;
  logic       start_wr, start_rd, set_err, sel_ok;
  logic [7:0] ext_rd_sel;

  // NOTE: every flop uses non-blocking assignment so all state updates see pre-edge values.
  always_ff @(posedge usb_clk or posedge reset) begin
    if (reset) begin
      O_ext_addr <= '0;
      O_ext_data <= '0;
      s1_rdn     <= IDLE_STROBE;
      s1_wrn     <= IDLE_STROBE;
      s1_cen     <= IDLE_STROBE;
    end else begin
      O_ext_addr <= I_usb_addr;
      O_ext_data <= I_usb_data;
      s1_rdn     <= I_usb_rdn;
      s1_wrn     <= I_usb_wrn;
      s1_cen     <= I_usb_cen;
    end
  end

  // NOTE: defaults at the top of every always_comb keep all paths assigned, so no latches.
  always_comb begin
    state_nxt = state;
    start_wr  = 1'b0;
    start_rd  = 1'b0;
    set_err   = 1'b0;
    sel_ok    = ({1'b0, I_ch_sel} < NUM_CH_V);
    case (state)
      ST_IDLE: begin
        if (!s1_cen) begin
          if (!s1_wrn && s1_rdn)       start_wr = 1'b1;
          else if (!s1_rdn && s1_wrn)  start_rd = 1'b1;
          else if (!s1_rdn && !s1_wrn) set_err  = 1'b1;
        end
        if (start_wr) state_nxt = ST_WRITE;
        if (start_rd) state_nxt = ST_READ;
        if ((start_wr || start_rd) && !sel_ok) set_err = 1'b1;
      end
      ST_WRITE: if (s1_wrn || s1_cen) state_nxt = ST_TURN;
      ST_READ:  if (s1_rdn || s1_cen) state_nxt = ST_TURN;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge usb_clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      O_active_ch <= '0;
      O_proto_err <= 1'b0;
      O_usb_data  <= '0;
    end else begin
      state <= state_nxt;
      if (start_wr || start_rd) O_active_ch <= I_ch_sel;
      if (set_err)        O_proto_err <= 1'b1;
      else if (I_err_clr) O_proto_err <= 1'b0;
      if (state == ST_READ) O_usb_data <= ext_rd_sel;
    end
  end

  // Out-of-range channels match no index: no strobes and read data of zero.
  always_comb begin
    ext_rd_sel = '0;
    O_ext_wrn  = {pNUM_CH{IDLE_STROBE}};
    O_ext_rdn  = {pNUM_CH{IDLE_STROBE}};
    O_ext_cen  = {pNUM_CH{IDLE_STROBE}};
    for (int i = 0; i < pNUM_CH; i++) begin
      if (O_active_ch == pCH_W'(i)) begin
        ext_rd_sel = I_ext_data[i*8 +: 8];
        if (state == ST_WRITE) begin
          O_ext_wrn[i] = s1_wrn;
          O_ext_cen[i] = s1_cen;
        end
        if (state == ST_READ) begin
          O_ext_rdn[i] = s1_rdn;
          O_ext_cen[i] = s1_cen;
        end
      end
    end
  end

  assign O_ext_data_oe = (state == ST_WRITE);
  assign O_usb_data_oe = (state == ST_READ);
  assign O_busy        = (state != ST_IDLE);

`ifdef USB_BRIDGE_STATS_EN
  usb_bridge_stats #(
    .pNUM_CH (pNUM_CH),
    .pCH_W   (pCH_W),
    .pCNT_W  (pCNT_W)
  ) u_stats (
    .usb_clk  (usb_clk),
    .reset    (reset),
    .stat_clr (I_stat_clr),
    .wr_inc   (start_wr && sel_ok),
    .rd_inc   (start_rd && sel_ok),
    .ch       (I_ch_sel),
    .wr_count (O_wr_count),
    .rd_count (O_rd_count)
  );
`else
  logic stat_clr_unused;
  assign stat_clr_unused = I_stat_clr;
  assign O_wr_count      = '0;
  assign O_rd_count      = '0;
`endif

endmodule

// File: tb/tb_usb_bus_bridge.sv
// Directed bench for usb_bus_bridge: cycle table for write/read/channel-lock/back-to-back, plus error, reset and stats sequences.
module tb_usb_bus_bridge;

  localparam int AW  = 11;
  localparam int NCH = 4;
  localparam int CHW = 3;
  localparam int CW  = 4;
`ifdef USB_BRIDGE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  // host strobe patterns {cen, wrn, rdn}
  localparam logic [2:0] H_I = 3'b111;
  localparam logic [2:0] H_W = 3'b001;
  localparam logic [2:0] H_R = 3'b010;
  localparam logic [2:0] H_X = 3'b000;

  logic              usb_clk = 1'b0;
  logic              reset   = 1'b1;
  logic [AW-1:0]     usb_addr = '0;
  logic [7:0]        usb_wdata = '0;
  logic [7:0]        usb_rdata;
  logic              usb_oe;
  logic              rdn = 1'b1, wrn = 1'b1, cen = 1'b1;
  logic [CHW-1:0]    ch_sel = '0;
  logic [AW-1:0]     ext_addr;
  logic [7:0]        ext_wdata;
  logic              ext_oe;
  logic [8*NCH-1:0]  ext_rdata = 32'h1122_C344;
  logic [NCH-1:0]    ext_rdn, ext_wrn, ext_cen;
  logic [CHW-1:0]    active_ch;
  logic              busy, proto_err;
  logic              err_clr = 1'b0, stat_clr = 1'b0;
  logic [CW*NCH-1:0] wr_count, rd_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 usb_clk = ~usb_clk;

  usb_bus_bridge #(
    .pADDR_WIDTH (AW),
    .pNUM_CH     (NCH),
    .pCH_W       (CHW),
    .pCNT_W      (CW)
  ) dut (
    .usb_clk       (usb_clk),
    .reset         (reset),
    .I_usb_addr    (usb_addr),
    .I_usb_data    (usb_wdata),
    .O_usb_data    (usb_rdata),
    .O_usb_data_oe (usb_oe),
    .I_usb_rdn     (rdn),
    .I_usb_wrn     (wrn),
    .I_usb_cen     (cen),
    .I_ch_sel      (ch_sel),
    .O_ext_addr    (ext_addr),
    .O_ext_data    (ext_wdata),
    .O_ext_data_oe (ext_oe),
    .I_ext_data    (ext_rdata),
    .O_ext_rdn     (ext_rdn),
    .O_ext_wrn     (ext_wrn),
    .O_ext_cen     (ext_cen),
    .O_active_ch   (active_ch),
    .O_busy        (busy),
    .O_proto_err   (proto_err),
    .I_err_clr     (err_clr),
    .I_stat_clr    (stat_clr),
    .O_wr_count    (wr_count),
    .O_rd_count    (rd_count)
  );

  typedef struct {
    logic [AW-1:0]  addr;
    logic [7:0]     data;
    logic [2:0]     host;
    logic [CHW-1:0] sel;
    logic [NCH-1:0] x_wrn;
    logic [NCH-1:0] x_rdn;
    logic [NCH-1:0] x_cen;
    logic           x_eoe;
    logic           x_uoe;
    logic           x_busy;
    logic [CHW-1:0] x_act;
    logic [7:0]     x_udata;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge usb_clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] h, input logic [CHW-1:0] s,
                       input logic [AW-1:0] a, input logic [7:0] d);
    {cen, wrn, rdn} = h;
    ch_sel    = s;
    usb_addr  = a;
    usb_wdata = d;
  endtask

  task automatic add(input logic [AW-1:0] a, input logic [7:0] d, input logic [2:0] h,
                     input logic [CHW-1:0] s, input logic [NCH-1:0] w, input logic [NCH-1:0] r,
                     input logic [NCH-1:0] c, input logic eoe, input logic uoe, input logic bsy,
                     input logic [CHW-1:0] act, input logic [7:0] ud);
    vec_t v;
    v.addr = a; v.data = d; v.host = h; v.sel = s;
    v.x_wrn = w; v.x_rdn = r; v.x_cen = c;
    v.x_eoe = eoe; v.x_uoe = uoe; v.x_busy = bsy; v.x_act = act; v.x_udata = ud;
    vecs.push_back(v);
  endtask

  task automatic check_idle_strobes(input string tag);
    check({tag, " wrn"}, 32'(ext_wrn), 32'hF);
    check({tag, " rdn"}, 32'(ext_rdn), 32'hF);
    check({tag, " cen"}, 32'(ext_cen), 32'hF);
  endtask

  initial begin
    // Row: inputs, then expected outputs #1 after the following clock edge.
    //  addr    data   host sel  wrn    rdn    cen   eoe  uoe  busy act  usb_data
    add(11'h000, 8'h00, H_I, 3'd0, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    add(11'h123, 8'h5A, H_W, 3'd2, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    add(11'h123, 8'h5A, H_W, 3'd2, 4'hB, 4'hF, 4'hB, 1'b1, 1'b0, 1'b1, 3'd2, 8'h00);
    add(11'h123, 8'h5A, H_I, 3'd0, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0, 1'b1, 3'd2, 8'h00);
    add(11'h123, 8'h5A, H_I, 3'd0, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0, 1'b1, 3'd2, 8'h00);
    add(11'h000, 8'h00, H_I, 3'd0, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 3'd2, 8'h00);
    add(11'h000, 8'h00, H_R, 3'd1, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 3'd2, 8'h00);
    add(11'h000, 8'h00, H_R, 3'd1, 4'hF, 4'hD, 4'hD, 1'b0, 1'b1, 1'b1, 3'd1, 8'h00);
    add(11'h000, 8'h00, H_R, 3'd1, 4'hF, 4'hD, 4'hD, 1'b0, 1'b1, 1'b1, 3'd1, 8'hC3);
    add(11'h000, 8'h00, H_R, 3'd1, 4'hF, 4'hD, 4'hD, 1'b0, 1'b1, 1'b1, 3'd1, 8'hC3);
    add(11'h000, 8'h00, H_I, 3'd1, 4'hF, 4'hF, 4'hF, 1'b0, 1'b1, 1'b1, 3'd1, 8'hC3);
    add(11'h000, 8'h00, H_I, 3'd1, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0, 1'b1, 3'd1, 8'hC3);
    add(11'h000, 8'h00, H_I, 3'd1, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 3'd1, 8'hC3);
    // channel select changes mid-write are ignored
    add(11'h7FF, 8'hA5, H_W, 3'd1, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 3'd1, 8'hC3);
    add(11'h7FF, 8'hA5, H_W, 3'd1, 4'hD, 4'hF, 4'hD, 1'b1, 1'b0, 1'b1, 3'd1, 8'hC3);
    add(11'h7FF, 8'hA5, H_W, 3'd3, 4'hD, 4'hF, 4'hD, 1'b1, 1'b0, 1'b1, 3'd1, 8'hC3);
    add(11'h7FF, 8'hA5, H_I, 3'd3, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0, 1'b1, 3'd1, 8'hC3);
    add(11'h7FF, 8'hA5, H_I, 3'd3, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0, 1'b1, 3'd1, 8'hC3);
    add(11'h2AA, 8'h3C, H_W, 3'd3, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 3'd1, 8'hC3);
    add(11'h2AA, 8'h3C, H_W, 3'd3, 4'h7, 4'hF, 4'h7, 1'b1, 1'b0, 1'b1, 3'd3, 8'hC3);
    add(11'h2AA, 8'h3C, H_I, 3'd3, 4'hF, 4'hF, 4'hF, 1'b1, 1'b0, 1'b1, 3'd3, 8'hC3);
    add(11'h2AA, 8'h3C, H_I, 3'd3, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0, 1'b1, 3'd3, 8'hC3);
    add(11'h2AA, 8'h3C, H_I, 3'd0, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 3'd3, 8'hC3);
    // write ch0 flowing straight into a read: TURN still inserted
    add(11'h055, 8'hE1, H_W, 3'd0, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 3'd3, 8'hC3);
    add(11'h055, 8'hE1, H_W, 3'd0, 4'hE, 4'hF, 4'hE, 1'b1, 1'b0, 1'b1, 3'd0, 8'hC3);
    add(11'h055, 8'hE1, H_R, 3'd0, 4'hF, 4'hF, 4'hE, 1'b1, 1'b0, 1'b1, 3'd0, 8'hC3);
    add(11'h055, 8'hE1, H_R, 3'd0, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0, 1'b1, 3'd0, 8'hC3);
    add(11'h055, 8'hE1, H_R, 3'd0, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 3'd0, 8'hC3);
    add(11'h055, 8'hE1, H_R, 3'd0, 4'hF, 4'hE, 4'hE, 1'b0, 1'b1, 1'b1, 3'd0, 8'hC3);
    add(11'h000, 8'h00, H_I, 3'd0, 4'hF, 4'hF, 4'hF, 1'b0, 1'b1, 1'b1, 3'd0, 8'h44);
    add(11'h000, 8'h00, H_I, 3'd0, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0, 1'b1, 3'd0, 8'h44);
    add(11'h000, 8'h00, H_I, 3'd0, 4'hF, 4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 3'd0, 8'h44);

    // reset state
    tick();
    tick();
    check_idle_strobes("rst");
    check("rst ext_oe", 32'(ext_oe), 32'h0);
    check("rst usb_oe", 32'(usb_oe), 32'h0);
    check("rst usb_data", 32'(usb_rdata), 32'h0);
    check("rst ext_addr", 32'(ext_addr), 32'h0);
    check("rst ext_data", 32'(ext_wdata), 32'h0);
    check("rst active_ch", 32'(active_ch), 32'h0);
    check("rst busy", 32'(busy), 32'h0);
    check("rst proto_err", 32'(proto_err), 32'h0);
    check("rst wr_count", 32'(wr_count), 32'h0);
    check("rst rd_count", 32'(rd_count), 32'h0);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].host, vecs[i].sel, vecs[i].addr, vecs[i].data);
      tick();
      check($sformatf("r%0d wrn", i), 32'(ext_wrn), 32'(vecs[i].x_wrn));
      check($sformatf("r%0d rdn", i), 32'(ext_rdn), 32'(vecs[i].x_rdn));
      check($sformatf("r%0d cen", i), 32'(ext_cen), 32'(vecs[i].x_cen));
      check($sformatf("r%0d ext_oe", i), 32'(ext_oe), 32'(vecs[i].x_eoe));
      check($sformatf("r%0d usb_oe", i), 32'(usb_oe), 32'(vecs[i].x_uoe));
      check($sformatf("r%0d busy", i), 32'(busy), 32'(vecs[i].x_busy));
      check($sformatf("r%0d active_ch", i), 32'(active_ch), 32'(vecs[i].x_act));
      check($sformatf("r%0d usb_data", i), 32'(usb_rdata), 32'(vecs[i].x_udata));
      check($sformatf("r%0d ext_addr", i), 32'(ext_addr), 32'(vecs[i].addr));
      check($sformatf("r%0d ext_data", i), 32'(ext_wdata), 32'(vecs[i].data));
    end
    check("table proto_err", 32'(proto_err), 32'h0);
    check("table wr_count", 32'(wr_count), STATS ? 32'h1111 : 32'h0);
    check("table rd_count", 32'(rd_count), STATS ? 32'h0011 : 32'h0);

    // all three host strobes low: protocol error, no transaction; set beats clear
    drive(H_X, 3'd2, 11'h010, 8'h00);
    tick();
    tick();
    check("both busy", 32'(busy), 32'h0);
    check_idle_strobes("both");
    check("both err set", 32'(proto_err), 32'h1);
    drive(H_I, 3'd0, 11'h010, 8'h00);
    err_clr = 1'b1;
    tick();
    check("err set wins", 32'(proto_err), 32'h1);
    tick();
    check("err cleared", 32'(proto_err), 32'h0);
    err_clr = 1'b0;

    // out-of-range channel read
    drive(H_R, 3'd5, 11'h020, 8'h00);
    tick();
    tick();
    check_idle_strobes("oor");
    check("oor busy", 32'(busy), 32'h1);
    check("oor usb_oe", 32'(usb_oe), 32'h1);
    check("oor active_ch", 32'(active_ch), 32'h5);
    check("oor err", 32'(proto_err), 32'h1);
    tick();
    check("oor usb_data", 32'(usb_rdata), 32'h0);
    check("oor rd_count", 32'(rd_count), STATS ? 32'h0011 : 32'h0);
    drive(H_I, 3'd0, 11'h000, 8'h00);
    tick();
    tick();
    tick();
    check("oor back idle", 32'(busy), 32'h0);

    // asynchronous reset in the middle of a read
    drive(H_R, 3'd1, 11'h030, 8'h00);
    tick();
    tick();
    check("pre-rst rdn", 32'(ext_rdn), 32'hD);
    #2 reset = 1'b1;
    #1;
    check_idle_strobes("async rst");
    check("async rst usb_oe", 32'(usb_oe), 32'h0);
    check("async rst ext_oe", 32'(ext_oe), 32'h0);
    check("async rst busy", 32'(busy), 32'h0);
    check("async rst err", 32'(proto_err), 32'h0);
    drive(H_I, 3'd0, 11'h000, 8'h00);
    tick();
    tick();
    reset = 1'b0;

    // counter saturation and clear-over-increment
    for (int n = 0; n < 17; n++) begin
      drive(H_W, 3'd0, 11'h040, 8'(n));
      tick();
      tick();
      drive(H_I, 3'd0, 11'h040, 8'(n));
      tick();
      tick();
      tick();
    end
    check("sat wr_count", 32'(wr_count), STATS ? 32'h000F : 32'h0);
    check("sat rd_count", 32'(rd_count), 32'h0);
    drive(H_W, 3'd0, 11'h041, 8'h00);
    tick();
    stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    check("clr wins wr_count", 32'(wr_count), 32'h0);
    drive(H_I, 3'd0, 11'h041, 8'h00);
    tick();
    tick();
    tick();
    drive(H_W, 3'd0, 11'h042, 8'h00);
    tick();
    tick();
    check("post-clr wr_count", 32'(wr_count), STATS ? 32'h0001 : 32'h0);
    drive(H_I, 3'd0, 11'h000, 8'h00);
    tick();
    tick();
    tick();
    check("final busy", 32'(busy), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
